disk_image_loader: RTL and testbench

- Receives a floppy disk image over the slow external byte interface (image_clk / image_start / image_data) and writes it into the track RAM feeding the Disk II emulation.
- Bridges the asynchronous image_clk strobe into the CLK_28M domain.
- Counts tracks and bytes, and issues one RAM write per received byte.
- Full image is 35 tracks x 6656 bytes = 232960 bytes at linear addresses 0..232959.

---
 rtl/disk_image_loader.sv | 155 +++++++++++++++
 tb/tb_disk_image_loader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/disk_image_loader.sv
// Disk image loader: synchronises a slow byte strobe into CLK_28M and writes
// each received byte of a TRACKS x TRACK_BYTES floppy image into track RAM.
module disk_image_loader #(
   parameter int TRACKS      = 35,
   parameter int TRACK_BYTES = 6656,
   parameter int ADDR_W      = 18
) (
   input  logic              CLK_28M,
   input  logic              RESET_N,
   input  logic              image_clk,
   input  logic              image_start,
   input  logic [7:0]        image_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [5:0]        track,
   output logic              track_done,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [12:0] LAST_OFF = 13'(TRACK_BYTES - 1);
   localparam logic [5:0]  LAST_TRK = 6'(TRACKS - 1);

   logic              clk_s1_r, clk_s2_r, clk_prev_r;
   logic              start_s1_r, start_s2_r;
   logic [7:0]        data_s1_r, data_s2_r;
   logic              ev_s, ev_r;

   state_t            state_r, state_nx;
   logic [12:0]       offset_r, offset_nx;
   logic [5:0]        track_r, track_nx;
   logic [ADDR_W-1:0] addr_r, addr_nx;
   logic              wr_en_r, wr_en_nx;
   logic [ADDR_W-1:0] wr_addr_r, wr_addr_nx;
   logic [7:0]        wr_data_r, wr_data_nx;
   logic              track_done_r, track_done_nx;
   logic              busy_r, done_r;

   assign ev_s = clk_s2_r & ~clk_prev_r;

   // Two-flop synchronisers and strobe edge detect; the event is registered so
   // start/data are consumed one cycle after detection.
   always_ff @(posedge CLK_28M or negedge RESET_N) begin
      if (!RESET_N) begin
         clk_s1_r   <= 1'b0;
         clk_s2_r   <= 1'b0;
         clk_prev_r <= 1'b0;
         start_s1_r <= 1'b0;
         start_s2_r <= 1'b0;
         data_s1_r  <= 8'h00;
         data_s2_r  <= 8'h00;
         ev_r       <= 1'b0;
      end else begin
         clk_s1_r   <= image_clk;
         clk_s2_r   <= clk_s1_r;
         clk_prev_r <= clk_s2_r;
         start_s1_r <= image_start;
         start_s2_r <= start_s1_r;
         data_s1_r  <= image_data;
         data_s2_r  <= data_s1_r;
         ev_r       <= ev_s;
      end
   end

   // Next-state, counter and write-port logic.
   always_comb begin
      state_nx      = state_r;
      offset_nx     = offset_r;
      track_nx      = track_r;
      addr_nx       = addr_r;
      wr_en_nx      = 1'b0;
      wr_addr_nx    = wr_addr_r;
      wr_data_nx    = wr_data_r;
      track_done_nx = 1'b0;
      if (ev_r) begin
         if (start_s2_r) begin
            state_nx   = RECV;
            offset_nx  = 13'd0;
            track_nx   = 6'd0;
            addr_nx    = {ADDR_W{1'b0}};
            wr_addr_nx = {ADDR_W{1'b0}};
         end else begin
            case (state_r)
               IDLE: state_nx = IDLE;
               DONE: state_nx = DONE;
               RECV: begin
                  wr_en_nx   = 1'b1;
                  wr_addr_nx = addr_r;
                  wr_data_nx = data_s2_r;
                  addr_nx    = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                  if (offset_r == LAST_OFF) begin
                     offset_nx     = 13'd0;
                     track_done_nx = 1'b1;
                     // Final track: stop here and keep track at its last value.
                     if (track_r == LAST_TRK) begin
                        state_nx = DONE;
                        addr_nx  = addr_r;
                     end else begin
                        track_nx = track_r + 6'd1;
                     end
                  end else begin
                     offset_nx = offset_r + 13'd1;
                  end
               end
               default: state_nx = IDLE;
            endcase
         end
      end else begin
         state_nx = state_r;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge CLK_28M or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r      <= IDLE;
         offset_r     <= 13'd0;
         track_r      <= 6'd0;
         addr_r       <= {ADDR_W{1'b0}};
         wr_en_r      <= 1'b0;
         wr_addr_r    <= {ADDR_W{1'b0}};
         wr_data_r    <= 8'h00;
         track_done_r <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         state_r      <= state_nx;
         offset_r     <= offset_nx;
         track_r      <= track_nx;
         addr_r       <= addr_nx;
         wr_en_r      <= wr_en_nx;
         wr_addr_r    <= wr_addr_nx;
         wr_data_r    <= wr_data_nx;
         track_done_r <= track_done_nx;
         busy_r       <= (state_nx == RECV);
         done_r       <= (state_nx == DONE);
      end
   end

   assign wr_en      = wr_en_r;
   assign wr_addr    = wr_addr_r;
   assign wr_data    = wr_data_r;
   assign track      = track_r;
   assign track_done = track_done_r;
   assign busy       = busy_r;
   assign done       = done_r;

endmodule

// File: tb/tb_disk_image_loader.sv
// Directed bench for disk_image_loader, scaled down to 3 tracks x 8 bytes so a
// full image, track boundaries and the stop pulse fit in a short run.
module tb_disk_image_loader;

   localparam int TRACKS      = 3;
   localparam int TRACK_BYTES = 8;
   localparam int ADDR_W      = 5;

   logic              clk;
   logic              rst_n;
   logic              image_clk;
   logic              image_start;
   logic [7:0]        image_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic [5:0]        track;
   logic              track_done;
   logic              busy;
   logic              done;

   int n_checks = 0;
   int n_pass   = 0;

   disk_image_loader #(
      .TRACKS      (TRACKS),
      .TRACK_BYTES (TRACK_BYTES),
      .ADDR_W      (ADDR_W)
   ) dut (
      .CLK_28M     (clk),
      .RESET_N     (rst_n),
      .image_clk   (image_clk),
      .image_start (image_start),
      .image_data  (image_data),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .track       (track),
      .track_done  (track_done),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // One image_clk pulse (5 cycles high, 5 low); records any write seen.
   task automatic pulse(input logic st, input logic [7:0] d, output int n_wr, output int lat,
                        output logic [31:0] a, output logic [7:0] dd, output logic td);
      n_wr = 0; lat = 0; a = 32'd0; dd = 8'h00; td = 1'b0;
      @(posedge clk);
      #2;
      image_start = st;
      image_data  = d;
      image_clk   = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         if (wr_en) begin
            n_wr++;
            lat = c;
            a   = 32'(wr_addr);
            dd  = wr_data;
            td  = track_done;
         end
         if (c == 5) image_clk = 1'b0;
      end
   endtask

   task automatic ctl(input string tag, input logic st, input logic [7:0] d);
      int n, l; logic [31:0] a; logic [7:0] dd; logic td;
      pulse(st, d, n, l, a, dd, td);
      check(tag, 32'(n), 32'd0);
   endtask

   task automatic wr_byte(input string tag, input logic [7:0] d, input int exp_a, input logic exp_td);
      int n, l; logic [31:0] a; logic [7:0] dd; logic td;
      pulse(1'b0, d, n, l, a, dd, td);
      check({tag, "_nwr"}, 32'(n), 32'd1);
      check({tag, "_lat"}, 32'(l >= 4 && l <= 5), 32'd1);
      check({tag, "_addr"}, a, 32'(exp_a));
      check({tag, "_data"}, 32'(dd), 32'(d));
      check({tag, "_tdone"}, 32'(td), 32'(exp_td));
   endtask

   initial begin
      logic [7:0] d;
      rst_n = 1'b0; image_clk = 1'b0; image_start = 1'b0; image_data = 8'h00;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_track", 32'(track), 32'd0);
      check("rst_addr", 32'(wr_addr), 32'd0);
      for (int i = 0; i < 3; i++) ctl("idle_nowr", 1'b0, 8'(8'hA0 + i));
      check("idle_busy", 32'(busy), 32'd0);

      // Start + 3 bytes
      ctl("start1", 1'b1, 8'h00);
      check("start1_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 3; i++) wr_byte("b3", 8'(i), i, 1'b0);

      // Track boundary: data = (track + i) % 256
      ctl("start2", 1'b1, 8'h00);
      for (int i = 0; i < TRACK_BYTES; i++) wr_byte("tb", 8'(i), i, i == TRACK_BYTES - 1);
      wr_byte("tb_next", 8'h01, TRACK_BYTES, 1'b0);
      check("tb_track", 32'(track), 32'd1);

      // Full image then stop pulse
      ctl("start3", 1'b1, 8'h00);
      for (int t = 0; t < TRACKS; t++)
         for (int i = 0; i < TRACK_BYTES; i++) begin
            d = 8'(t + i);
            wr_byte("full", d, t * TRACK_BYTES + i, i == TRACK_BYTES - 1);
         end
      check("full_done", 32'(done), 32'd1);
      check("full_busy", 32'(busy), 32'd0);
      check("full_track", 32'(track), 32'(TRACKS - 1));
      check("full_addr", 32'(wr_addr), 32'(TRACKS * TRACK_BYTES - 1));
      ctl("stop_nowr", 1'b0, 8'h00);
      check("stop_done", 32'(done), 32'd1);
      check("stop_addr", 32'(wr_addr), 32'(TRACKS * TRACK_BYTES - 1));

      // Restart mid-transfer
      ctl("start4", 1'b1, 8'h00);
      check("restart_done_clr", 32'(done), 32'd0);
      for (int i = 0; i < 10; i++) wr_byte("pre", 8'(8'h40 + i), i, i == TRACK_BYTES - 1);
      ctl("restart", 1'b1, 8'h00);
      check("restart_busy", 32'(busy), 32'd1);
      check("restart_track", 32'(track), 32'd0);
      wr_byte("after", 8'h5A, 0, 1'b0);
      check("after_track", 32'(track), 32'd0);
      check("after_busy", 32'(busy), 32'd1);

      // Asynchronous reset between clock edges
      ctl("start5", 1'b1, 8'h00);
      for (int i = 0; i < 5; i++) wr_byte("ar", 8'(8'h80 + i), i, 1'b0);
      check("ar_busy_pre", 32'(busy), 32'd1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_addr", 32'(wr_addr), 32'd0);
      check("ar_data", 32'(wr_data), 32'd0);
      check("ar_wr_en", 32'(wr_en), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) ctl("ar_nowr", 1'b0, 8'(8'h11 + i));
      check("ar_busy_post", 32'(busy), 32'd0);
      check("ar_done_post", 32'(done), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
